// File: rtl/conv1x1_coeff_ctrl_pkg.sv
// Shared definitions for the 1x1 coefficient controller: address map,
// FSM encoding and the identity reset pattern for the weight bank.
package conv1x1_coeff_ctrl_pkg;

    localparam int ADDR_W0   = 0;
    localparam int ADDR_B0   = 9;
    localparam int ADDR_LAST = 11;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ARMED,
        ST_DRAIN,
        ST_SWAP
    } state_t;

    // Weight k maps to (o = k / ic, i = k % ic); identity has ones on o == i.
    function automatic logic identity_weight(int k, int ic);
        return (k / ic) == (k % ic);
    endfunction

endpackage

// File: rtl/conv1x1_coeff_ctrl_if.sv
// AXI4-Stream link used on both sides of the controller.
interface conv1x1_coeff_ctrl_if #(
    parameter int DATA_W = 48
);
    logic [DATA_W-1:0] tdata;
    logic              tvalid;
    logic              tready;
    logic              tlast;
    logic [2:0]        tuser;

    modport master (output tdata, tvalid, tlast, tuser, input tready);
    modport slave  (input tdata, tvalid, tlast, tuser, output tready);
endinterface

// File: rtl/conv1x1_coeff_ctrl_coeff_bank.sv
// Shadow/active coefficient registers: writes land in shadow, a swap
// strobe copies the whole shadow bank into active in one cycle.
module conv1x1_coeff_ctrl_coeff_bank
    import conv1x1_coeff_ctrl_pkg::*;
#(
    parameter int IC = 3,
    parameter int OC = 3,
    parameter int WW = 8,
    parameter int BW = 16
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [3:0]            wr_addr,
    input  logic [15:0]           wr_data,
    input  logic                  swap,
    output logic [WW*IC*OC-1:0]   weights_flat,
    output logic [BW*OC-1:0]      biases_flat
);
    logic [IC*OC-1:0][WW-1:0] w_sh, w_act;
    logic [OC-1:0][BW-1:0]    b_sh, b_act;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < IC*OC; k++) begin
                w_sh[k]  <= WW'(identity_weight(k, IC));
                w_act[k] <= WW'(identity_weight(k, IC));
            end
            b_sh  <= '0;
            b_act <= '0;
        end else begin
            // Out-of-map addresses match nothing here and are simply dropped.
            for (int k = 0; k < IC*OC; k++)
                if (wr_en && wr_addr == 4'(ADDR_W0 + k)) w_sh[k] <= wr_data[WW-1:0];
            for (int o = 0; o < OC; o++)
                if (wr_en && wr_addr == 4'(ADDR_B0 + o)) b_sh[o] <= wr_data[BW-1:0];
            if (swap) begin
                w_act <= w_sh;
                b_act <= b_sh;
            end
        end
    end

    assign weights_flat = w_act;
    assign biases_flat  = b_act;
endmodule

// File: rtl/conv1x1_coeff_ctrl.sv
// In-line stream gate plus bank-swap sequencer: a committed coefficient set
// becomes active only between frames, after the datapath has emptied.
module conv1x1_coeff_ctrl
    import conv1x1_coeff_ctrl_pkg::*;
#(
    parameter int INPUT_CHANNELS  = 3,
    parameter int OUTPUT_CHANNELS = 3,
    parameter int DATA_WIDTH      = 16,
    parameter int WEIGHT_WIDTH    = 8,
    parameter int BIAS_WIDTH      = 16,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_wr_valid,
    output logic                       cfg_wr_ready,
    input  logic [3:0]                 cfg_wr_addr,
    input  logic [15:0]                cfg_wr_data,
    input  logic                       cfg_commit,
    output logic                       cfg_commit_pending,
    output logic                       cfg_err,
    input  logic                       cfg_err_clr,
    conv1x1_coeff_ctrl_if.slave        s_axis,
    conv1x1_coeff_ctrl_if.master       m_axis,
    input  logic                       dp_out_tvalid,
    input  logic                       dp_out_tready,
    output logic [WEIGHT_WIDTH*INPUT_CHANNELS*OUTPUT_CHANNELS-1:0] weights_flat,
    output logic [BIAS_WIDTH*OUTPUT_CHANNELS-1:0]                  biases_flat,
    output logic [CNT_WIDTH-1:0]       swap_count
);
    localparam int TDATA_W = DATA_WIDTH * INPUT_CHANNELS;

    state_t     state;
    logic       hold_q, sof_block_q;
    logic [1:0] inflight;
    logic       gate, m_hs, dp_hs, wr_fire, swap;

    // In ARMED only an SOF beat is blocked; ordinary beats keep flowing.
    assign gate          = hold_q | (sof_block_q & s_axis.tvalid & s_axis.tuser[0]);
    assign m_axis.tdata  = TDATA_W'(s_axis.tdata);
    assign m_axis.tlast  = s_axis.tlast;
    assign m_axis.tuser  = s_axis.tuser;
    assign m_axis.tvalid = s_axis.tvalid & ~gate;
    assign s_axis.tready = m_axis.tready & ~gate;

    assign m_hs    = m_axis.tvalid & m_axis.tready;
    assign dp_hs   = dp_out_tvalid & dp_out_tready;
    assign wr_fire = cfg_wr_valid & cfg_wr_ready;
    assign swap    = (state == ST_SWAP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state              <= ST_IDLE;
            cfg_wr_ready       <= 1'b1;
            cfg_commit_pending <= 1'b0;
            hold_q             <= 1'b0;
            sof_block_q        <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: if (cfg_commit) begin
                    state              <= ST_ARMED;
                    cfg_wr_ready       <= 1'b0;
                    cfg_commit_pending <= 1'b1;
                    sof_block_q        <= 1'b1;
                end
                ST_ARMED: if (s_axis.tvalid && s_axis.tuser[0]) begin
                    state       <= ST_DRAIN;
                    sof_block_q <= 1'b0;
                    hold_q      <= 1'b1;
                end
                ST_DRAIN: if (inflight == 2'd0) state <= ST_SWAP;
                ST_SWAP: begin
                    state              <= ST_IDLE;
                    hold_q             <= 1'b0;
                    cfg_wr_ready       <= 1'b1;
                    cfg_commit_pending <= 1'b0;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            inflight   <= '0;
            swap_count <= '0;
            cfg_err    <= 1'b0;
        end else begin
            if (m_hs && !dp_hs)      inflight <= inflight + 2'd1;
            else if (dp_hs && !m_hs) inflight <= inflight - 2'd1;
            if (swap) swap_count <= swap_count + 1'b1;
            // A new error wins over a simultaneous clear.
            if (wr_fire && cfg_wr_addr > 4'(ADDR_LAST)) cfg_err <= 1'b1;
            else if (cfg_err_clr)                       cfg_err <= 1'b0;
        end
    end

    a_inflight_ovf: assert property (@(posedge clk) disable iff (!rst_n)
        !(m_hs && !dp_hs && inflight == 2'd3));
    a_inflight_udf: assert property (@(posedge clk) disable iff (!rst_n)
        !(dp_hs && !m_hs && inflight == 2'd0));

    conv1x1_coeff_ctrl_coeff_bank #(
        .IC(INPUT_CHANNELS), .OC(OUTPUT_CHANNELS), .WW(WEIGHT_WIDTH), .BW(BIAS_WIDTH)
    ) u_bank (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_fire),
        .wr_addr      (cfg_wr_addr),
        .wr_data      (cfg_wr_data),
        .swap         (swap),
        .weights_flat (weights_flat),
        .biases_flat  (biases_flat)
    );
endmodule
